// File: rtl/stream_unpacker.sv
// stream_unpacker: valid/ready width-down converter emitting one ELEM_W field per beat from a packed word
module stream_unpacker #(
  parameter int ELEM_W    = 8,
  parameter int N_ELEM    = 4,
  parameter int MSB_FIRST = 1,
  localparam int CW       = (N_ELEM > 2) ? $clog2(N_ELEM) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic [N_ELEM*ELEM_W-1:0] i_data,
  input  logic [CW-1:0]            i_nElemM1,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [ELEM_W-1:0]        o_data,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     i_ready
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_d;
  logic [N_ELEM*ELEM_W-1:0] word, sh;
  logic [CW-1:0] cnt, num, num_in;
  logic emit, in_xfer, out_xfer;
  assign emit     = state == EMIT;
  assign o_valid  = emit;
  assign o_last   = emit & (cnt == num);
  assign o_ready  = ~emit | (i_ready & o_last);
  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = o_valid & i_ready;
  assign num_in   = (i_nElemM1 > CW'(N_ELEM - 1)) ? CW'(N_ELEM - 1) : i_nElemM1;
  // shift the selected element to the emit-first end of the buffer
  assign sh       = (MSB_FIRST != 0) ? word << (cnt * ELEM_W) : word >> (cnt * ELEM_W);
  assign o_data   = !emit ? '0 : (MSB_FIRST != 0) ? sh[N_ELEM*ELEM_W-1 -: ELEM_W] : sh[ELEM_W-1:0];
  always_comb begin
    state_d = state;
    state_d = in_xfer ? EMIT : (out_xfer & o_last) ? IDLE : state;
  end
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= IDLE;
      word  <= '0;
      cnt   <= '0;
      num   <= '0;
    end else begin
      state <= state_d;
      if (in_xfer) begin
        word <= i_data;
        num  <= num_in;
        cnt  <= '0;
      end else if (out_xfer & ~o_last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_unpacker.sv
// tb_stream_unpacker: directed checks of stream_unpacker (MSB-first, LSB-first and 3-element clamp variants)
module tb_stream_unpacker;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] i_data = '0;
  logic [1:0]  nm = '0;
  logic        i_valid = 0;
  logic        i_ready = 0;
  logic        rdy_m, last_m, val_m;
  logic [7:0]  dat_m;
  logic        rdy_l, last_l, val_l;
  logic [7:0]  dat_l;
  logic        rdy_3, last_3, val_3;
  logic [7:0]  dat_3;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stream_unpacker #(.ELEM_W(8), .N_ELEM(4), .MSB_FIRST(1)) u_msb (
    .i_clk(clk), .i_arst_n(rst_n), .i_data(i_data), .i_nElemM1(nm), .i_valid(i_valid),
    .o_ready(rdy_m), .o_data(dat_m), .o_last(last_m), .o_valid(val_m), .i_ready(i_ready));
  stream_unpacker #(.ELEM_W(8), .N_ELEM(4), .MSB_FIRST(0)) u_lsb (
    .i_clk(clk), .i_arst_n(rst_n), .i_data(i_data), .i_nElemM1(nm), .i_valid(i_valid),
    .o_ready(rdy_l), .o_data(dat_l), .o_last(last_l), .o_valid(val_l), .i_ready(i_ready));
  stream_unpacker #(.ELEM_W(8), .N_ELEM(3), .MSB_FIRST(1)) u_three (
    .i_clk(clk), .i_arst_n(rst_n), .i_data(i_data[23:0]), .i_nElemM1(nm), .i_valid(i_valid),
    .o_ready(rdy_3), .o_data(dat_3), .o_last(last_3), .o_valid(val_3), .i_ready(i_ready));

  task automatic test_reset;
    rst_n = 0; i_valid = 1; i_data = 32'hAABBCCDD; nm = 3; i_ready = 1;
    repeat (3) @(negedge clk);
    total++; if (val_m !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", val_m); end
    total++; if (dat_m !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", dat_m); end
    total++; if (last_m !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", last_m); end
    i_valid = 0;
    rst_n = 1;
    @(negedge clk);
    total++; if (rdy_m !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", rdy_m); end
    total++; if (val_m !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b want=0", val_m); end
  endtask

  task automatic test_full_word;
    logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    i_data = 32'hAABBCCDD; nm = 3; i_valid = 1; i_ready = 1;
    total++; if (rdy_m !== 1'b1) begin bad++; $display("FAIL full_accept_ready got=%b want=1", rdy_m); end
    @(negedge clk);
    i_valid = 0;
    for (int k = 0; k < 4; k++) begin
      total++; if (val_m !== 1'b1) begin bad++; $display("FAIL full_valid[%0d] got=%b want=1", k, val_m); end
      total++; if (dat_m !== exp[k]) begin bad++; $display("FAIL full_data[%0d] got=%h want=%h", k, dat_m, exp[k]); end
      total++; if (last_m !== (k == 3)) begin bad++; $display("FAIL full_last[%0d] got=%b want=%b", k, last_m, k == 3); end
      total++; if (rdy_m !== (k == 3)) begin bad++; $display("FAIL full_ready[%0d] got=%b want=%b", k, rdy_m, k == 3); end
      @(negedge clk);
    end
    total++; if (val_m !== 1'b0) begin bad++; $display("FAIL full_end_valid got=%b want=0", val_m); end
  endtask

  task automatic test_back_to_back;
    i_data = 32'h01020304; nm = 3; i_valid = 1; i_ready = 1;
    @(negedge clk);
    i_data = 32'h05060708;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) i_valid = 0;
      total++; if (val_m !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=1", k, val_m); end
      total++; if (dat_m !== 8'(k + 1)) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", k, dat_m, 8'(k + 1)); end
      total++; if (rdy_m !== (k == 3 || k == 7)) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=%b", k, rdy_m, k == 3 || k == 7); end
      total++; if (last_m !== (k == 3 || k == 7)) begin bad++; $display("FAIL b2b_last[%0d] got=%b want=%b", k, last_m, k == 3 || k == 7); end
      @(negedge clk);
    end
    total++; if (val_m !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b want=0", val_m); end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int idx = 0;
    i_data = 32'hAABBCCDD; nm = 3; i_valid = 1; i_ready = 1;
    @(negedge clk);
    i_valid = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      i_ready = (c < 5) ? pat[c] : 1'b1;
      #1;
      total++; if (val_m !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b want=1", c, val_m); end
      total++; if (dat_m !== exp[idx]) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", c, dat_m, exp[idx]); end
      total++; if (last_m !== (idx == 3)) begin bad++; $display("FAIL bp_last[%0d] got=%b want=%b", c, last_m, idx == 3); end
      total++; if (rdy_m !== (i_ready && idx == 3)) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=%b", c, rdy_m, i_ready && idx == 3); end
      if (i_ready) idx++;
      @(negedge clk);
    end
    i_ready = 1;
    total++; if (idx != 4) begin bad++; $display("FAIL bp_timeout beats=%0d want=4", idx); end
    total++; if (val_m !== 1'b0) begin bad++; $display("FAIL bp_end_valid got=%b want=0", val_m); end
  endtask

  task automatic test_short_word;
    i_data = 32'hAABBCCDD; nm = 1; i_valid = 1; i_ready = 1;
    @(negedge clk);
    i_valid = 0;
    total++; if (dat_m !== 8'hAA || last_m !== 1'b0) begin bad++; $display("FAIL short_beat0 got=%h/%b want=aa/0", dat_m, last_m); end
    @(negedge clk);
    total++; if (dat_m !== 8'hBB || last_m !== 1'b1) begin bad++; $display("FAIL short_beat1 got=%h/%b want=bb/1", dat_m, last_m); end
    @(negedge clk);
    total++; if (val_m !== 1'b0) begin bad++; $display("FAIL short_end_valid got=%b want=0", val_m); end
  endtask

  task automatic test_single_beat;
    i_data = 32'h12345678; nm = 0; i_valid = 1; i_ready = 1;
    @(negedge clk);
    i_valid = 0;
    total++; if (dat_m !== 8'h12 || last_m !== 1'b1 || rdy_m !== 1'b1) begin bad++; $display("FAIL single_beat got=%h/%b/%b want=12/1/1", dat_m, last_m, rdy_m); end
    @(negedge clk);
    total++; if (val_m !== 1'b0) begin bad++; $display("FAIL single_end_valid got=%b want=0", val_m); end
  endtask

  task automatic test_lsb_first;
    logic [7:0] exp [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    i_data = 32'hAABBCCDD; nm = 3; i_valid = 1; i_ready = 1;
    @(negedge clk);
    i_valid = 0;
    for (int k = 0; k < 4; k++) begin
      total++; if (val_l !== 1'b1 || dat_l !== exp[k] || last_l !== (k == 3)) begin bad++; $display("FAIL lsb_beat[%0d] got=%b/%h/%b want=1/%h/%b", k, val_l, dat_l, last_l, exp[k], k == 3); end
      @(negedge clk);
    end
    total++; if (val_l !== 1'b0) begin bad++; $display("FAIL lsb_end_valid got=%b want=0", val_l); end
  endtask

  task automatic test_clamp;
    logic [7:0] exp [3] = '{8'hBB, 8'hCC, 8'hDD};
    i_data = 32'hAABBCCDD; nm = 3; i_valid = 1; i_ready = 1;
    @(negedge clk);
    i_valid = 0;
    for (int k = 0; k < 3; k++) begin
      total++; if (val_3 !== 1'b1 || dat_3 !== exp[k] || last_3 !== (k == 2)) begin bad++; $display("FAIL clamp_beat[%0d] got=%b/%h/%b want=1/%h/%b", k, val_3, dat_3, last_3, exp[k], k == 2); end
      @(negedge clk);
    end
    total++; if (val_3 !== 1'b0) begin bad++; $display("FAIL clamp_end_valid got=%b want=0", val_3); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    i_data = 32'hAABBCCDD; nm = 3; i_valid = 1; i_ready = 1;
    @(negedge clk);
    i_valid = 0;
    total++; if (dat_m !== 8'hAA) begin bad++; $display("FAIL mid_beat0 got=%h want=aa", dat_m); end
    @(negedge clk);
    total++; if (dat_m !== 8'hBB) begin bad++; $display("FAIL mid_beat1 got=%h want=bb", dat_m); end
    @(negedge clk);
    rst_n = 0;
    #1;
    total++; if (val_m !== 1'b0 || dat_m !== 8'h00 || last_m !== 1'b0) begin bad++; $display("FAIL mid_async got=%b/%h/%b want=0/00/0", val_m, dat_m, last_m); end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (val_m !== 1'b0) begin bad++; $display("FAIL mid_no_partial[%0d] got=%b/%h want=0", c, val_m, dat_m); end
    end
    i_data = 32'h11223344; nm = 3; i_valid = 1;
    @(negedge clk);
    i_valid = 0;
    total++; if (val_m !== 1'b1 || dat_m !== 8'h11 || last_m !== 1'b0) begin bad++; $display("FAIL mid_restart got=%b/%h/%b want=1/11/0", val_m, dat_m, last_m); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_word();
    test_back_to_back();
    test_backpressure();
    test_short_word();
    test_single_beat();
    test_lsb_first();
    test_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
